prbs_checker: RTL
=================

# prbs_checker

Serial PRBS checker: the receive-side counterpart of the 32-bit LFSR pattern source. It self-synchronises to an incoming bit stream generated by the same polynomial, declares lock after a run of correct predictions, then counts bit errors and checked bits. It sits at the link/loopback test endpoint, fed by the deserialised data path.

## Interface
- `LOCK_LEN`, 16: consecutive correct predictions in VERIFY required to enter LOCKED (1..255).
- `UNLOCK_ERRS`, 8: consecutive mismatches in LOCKED that force a reseed (1..255).
- `ERR_W`, 16: width of the error counter.
- `BIT_W`, 32: width of the checked-bit counter.

- `clk_i`, input, 1: clock; all logic is on the rising edge.
- `reset_ni`, input, 1: asynchronous, active-low reset.
- `data_i`, input, 1: received serial bit.
- `valid_i`, input, 1: `data_i` is valid this cycle. The block does nothing when low.
- `clear_i`, input, 1: synchronous clear of `err_cnt_o` and `bit_cnt_o`.
- `locked_o`, output, 1: high while the state is LOCKED.
- `err_o`, output, 1: one-cycle pulse for each mismatch while LOCKED.
- `err_cnt_o`, output, ERR_W: saturating count of mismatches seen in LOCKED.
- `bit_cnt_o`, output, BIT_W: saturating count of bits checked in LOCKED.

## Operation
- **Stream definition.** Each valid bit is the generator's feedback bit: the parity of (state AND `TAP_MASK`). `TAP_MASK` is 32'h088C_8892 (taps 27, 23, 19, 18, 15, 11, 7, 4, 1). The generator state shifts left with the new bit in the LSB.
- **Local register.** The local 32-bit register `rx` mirrors the generator state. The predicted bit is parity(`rx` & `TAP_MASK`).
- **State machine.** States are SEED, VERIFY and LOCKED. Reset enters SEED.
- **SEED.**
  - On each valid bit: `rx <= {rx[30:0], data_i}` and `seed_cnt++`.
  - After the 32nd valid bit, the next state is VERIFY.
  - Exception: if the new `rx` is all-zero, stay in SEED with `seed_cnt=0`. An all-zero stream can never lock.
- **VERIFY.**
  - On each valid bit, compare `data_i` with the predicted bit, then shift `rx` with `data_i`.
  - On a match, `run_cnt++`. When `run_cnt` reaches `LOCK_LEN`, go to LOCKED.
  - On a mismatch, go to SEED with `seed_cnt=0` and `run_cnt=0`.
- **LOCKED.**
  - On each valid bit, shift `rx` with the **predicted** bit, not `data_i`. This prevents a single channel error from propagating into the prediction.
  - `bit_cnt` increments on every valid bit.
  - On a mismatch: pulse `err_o`, increment `err_cnt`, increment `bad_run`.
  - On a match: `bad_run=0`.
  - When `bad_run` reaches `UNLOCK_ERRS`, go to SEED with `seed_cnt=0`, `run_cnt=0`, `bad_run=0`. Counters hold their values.
- **Counters.** Both counters saturate at all-ones and never wrap.
- **clear_i.** Clear has priority over an increment in the same cycle: the counter becomes 0 and that cycle's event is not counted. `err_o` still pulses. Clear does not affect the state or `rx`.
- **Gaps in valid_i.** When `valid_i=0`, all state, counters and `rx` hold, and `err_o=0`. Gaps of any length are legal in every state.

## Timing
- **Reset values.** `locked_o=0`, `err_o=0`, `err_cnt_o=0`, `bit_cnt_o=0`, `rx=0`, state SEED, all internal counters 0.
- **Registered outputs.** All outputs are registered. An event on a valid cycle N is visible in cycle N+1.
- **Lock latency.** From reset, a clean stream sets `locked_o` high one cycle after valid bit number 32+`LOCK_LEN` (bit 48 with defaults).
- **Unlock.** `locked_o` falls one cycle after the `UNLOCK_ERRS`-th consecutive mismatch.
- **First checked bit.** The first bit checked in LOCKED is the valid bit after the one that completed VERIFY.
- **Reset mid-operation.** Asserting `reset_ni` low during any state returns all outputs to their reset values immediately (asynchronously). Operation restarts from SEED after deassertion.

## Structure
- **Shared package `prbs_pkg`.** Holds `LFSR_W=32`, `TAP_MASK=32'h088C_8892`, the generator reset seed `SEED_DEFAULT=32'd12448672` (0x00BD_F3A0), and the state enum `prbs_chk_state_e` {SEED, VERIFY, LOCKED}.
- **Sub-module `prbs_predict`.** A combinational module taking the 32-bit state and producing the predicted bit and the next state. The same module is shareable with the generator.

## Test plan
- **Clean lock.** Generator seeded 0x00BD_F3A0 drives the stream continuously. Required: `locked_o` rises 1 cycle after valid bit 48; `err_cnt_o` stays 0; `bit_cnt_o=100` after 100 further bits.
- **Single error.** Once locked, invert one bit. Required: `err_o` pulses exactly once; `err_cnt_o=1`; `locked_o` stays 1; following bits produce no further errors.
- **Burst unlock.** Once locked, invert 8 consecutive bits. Required: `locked_o` falls after the 8th; relock occurs 48 clean bits later; `err_cnt_o=8` is retained.
- **All-zero stream.** Drive 200 zero bits. Required: `locked_o` never rises; counters stay 0.
- **valid_i gaps and clear.** Insert random `valid_i=0` gaps during lock. Required: lock timing counts only valid bits. Assert `clear_i` in the same cycle as a mismatch. Required: `err_cnt_o=0` the next cycle, and `err_o` pulses.
- **Reset mid-lock.** Pull `reset_ni` low while locked with `err_cnt_o=3`. Required: all outputs are 0 immediately; relock after 48 valid bits following release.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared constants and state type for the 32-bit PRBS source and checker.
package prbs_pkg;
  localparam int LFSR_W = 32;
  localparam logic [LFSR_W-1:0] TAP_MASK = 32'h088C_8892;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 32'd12448672;
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} prbs_chk_state_e;
endpackage

// File: rtl/prbs_predict.sv
// prbs_predict: next feedback bit and advanced LFSR state for a given state.
module prbs_predict
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] state,
  output logic              pred,
  output logic [LFSR_W-1:0] next_state
);
  assign pred = ^(state & TAP_MASK);
  assign next_state = {state[LFSR_W-2:0], pred};
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock detection and error/bit counters.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_LEN    = 16,
  parameter int UNLOCK_ERRS = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             data_i,
  input  logic             valid_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [BIT_W-1:0] bit_cnt_o
);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_LEN - 1);
  localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_ERRS - 1);

  prbs_chk_state_e state_q, state_d;
  logic [LFSR_W-1:0] rx_q, rx_d, rx_pred, shifted;
  logic [5:0] seed_q, seed_d;
  logic [7:0] run_q, run_d, bad_q, bad_d;
  logic pred, miss, err_ev, bit_ev;

  prbs_predict u_predict (.state(rx_q), .pred(pred), .next_state(rx_pred));

  assign shifted = {rx_q[LFSR_W-2:0], data_i};
  assign miss = data_i != pred;

  always_comb begin
    state_d = state_q;
    rx_d = rx_q;
    seed_d = seed_q;
    run_d = run_q;
    bad_d = bad_q;
    err_ev = 1'b0;
    bit_ev = 1'b0;
    if (valid_i) begin
      case (state_q)
        SEED: begin
          rx_d = shifted;
          seed_d = shifted == '0 ? 6'd0 : seed_q == 6'd31 ? 6'd0 : seed_q + 6'd1;
          state_d = (shifted != '0 && seed_q == 6'd31) ? VERIFY : SEED;
        end
        VERIFY: begin
          rx_d = shifted;
          run_d = (miss || run_q == LOCK_LAST) ? 8'd0 : run_q + 8'd1;
          state_d = miss ? SEED : run_q == LOCK_LAST ? LOCKED : VERIFY;
          seed_d = 6'd0;
        end
        LOCKED: begin
          // feed back the prediction so channel errors never corrupt rx
          rx_d = rx_pred;
          bit_ev = 1'b1;
          err_ev = miss;
          bad_d = (miss && bad_q != UNLOCK_LAST) ? bad_q + 8'd1 : 8'd0;
          state_d = (miss && bad_q == UNLOCK_LAST) ? SEED : LOCKED;
          seed_d = 6'd0;
          run_d = 8'd0;
        end
        default: state_d = SEED;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= SEED;
      rx_q <= '0;
      seed_q <= '0;
      run_q <= '0;
      bad_q <= '0;
      locked_o <= 1'b0;
      err_o <= 1'b0;
      err_cnt_o <= '0;
      bit_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      rx_q <= rx_d;
      seed_q <= seed_d;
      run_q <= run_d;
      bad_q <= bad_d;
      locked_o <= state_d == LOCKED;
      err_o <= err_ev;
      if (clear_i) err_cnt_o <= '0;
      else if (err_ev && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_W'(1);
      if (clear_i) bit_cnt_o <= '0;
      else if (bit_ev && !(&bit_cnt_o)) bit_cnt_o <= bit_cnt_o + BIT_W'(1);
    end
  end
endmodule
